keypad_scanner: RTL and testbench

Column-scan controller for the 4x4 matrix keypad that sequences the existing debouncer. Drives one column low at a time, samples the synchronized rows after a settle window, and encodes a single pressed key to a hex digit. On a press it freezes the scan and holds `pressed`/`key` stable until the key is released. This gives the debouncer a glitch-free, column-independent press level and key code on its `pressed`/`itemp` inputs.

---
 rtl/keypad_scanner_pkg.sv | 30 +++
 rtl/keypad_scanner_row_sync.sv | 27 ++
 rtl/keypad_scanner.sv | 135 +++++++++++++
 tb/tb_keypad_scanner.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/keypad_scanner_pkg.sv
// Shared types and constants for the 4x4 keypad scanner and its downstream debouncer.
// Pure declarations: no latency, no flow control.
package keypad_pkg;

    typedef enum logic [1:0] {
        DRIVE,
        SAMPLE,
        HOLD
    } scan_state_t;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;
    localparam int KEY_W    = 4;

    localparam logic [KEY_W-1:0] KEYMAP [NUM_ROWS][NUM_COLS] = '{
        '{4'h1, 4'h2, 4'h3, 4'hA},
        '{4'h4, 4'h5, 4'h6, 4'hB},
        '{4'h7, 4'h8, 4'h9, 4'hC},
        '{4'hE, 4'h0, 4'hF, 4'hD}
    };

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic [NUM_COLS-1:0] col_drive(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/keypad_scanner_row_sync.sv
// Two-flop synchronizer for the asynchronous keypad rows, resetting to all-ones (idle).
// Latency 2 cycles; no backpressure.
module row_sync #(
    parameter int W = 4
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_meta;
    logic [W-1:0] r_sync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= '1;
            r_sync <= '1;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/keypad_scanner.sv
// Column-scan controller: one-cold column drive, settle-then-sample, freezes on a single press until release.
// Press visible one edge after SAMPLE; no backpressure, outputs are registered levels.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SETTLE_CYCLES  = 120,
    parameter int RELEASE_CYCLES = 1200
) (
    input  logic                int_osc,
    input  logic                reset,
    input  logic [NUM_ROWS-1:0] rows,
    output logic [NUM_COLS-1:0] cols,
    output logic                pressed,
    output logic [KEY_W-1:0]    key
);

    localparam int CNT_W = $clog2(max_int(SETTLE_CYCLES, RELEASE_CYCLES)) + 1;
    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RELEASE_LAST = CNT_W'(RELEASE_CYCLES - 1);

    scan_state_t         r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [1:0]          r_col_idx;
    logic [NUM_COLS-1:0] r_cols;
    logic                r_pressed;
    logic [KEY_W-1:0]    r_key;

    scan_state_t         w_state_nxt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic [1:0]          w_col_nxt;
    logic [NUM_COLS-1:0] w_cols_nxt;
    logic                w_pressed_nxt;
    logic [KEY_W-1:0]    w_key_nxt;

    logic [NUM_ROWS-1:0] w_rows_s;
    logic [NUM_ROWS-1:0] w_low;
    logic                w_single;
    logic [1:0]          w_row_idx;
    logic [1:0]          w_col_inc;

    row_sync #(.W(NUM_ROWS)) u_row_sync (
        .i_clk   (int_osc),
        .i_rst_n (reset),
        .i_d     (rows),
        .o_q     (w_rows_s)
    );

    // Exactly one row low is a valid press; ghosting/multi-key reads are skipped.
    assign w_low     = ~w_rows_s;
    assign w_single  = (w_low != '0) && ((w_low & (w_low - 4'd1)) == '0);
    assign w_col_inc = r_col_idx + 2'd1;

    always_comb begin
        w_row_idx = 2'd0;
        for (int r = NUM_ROWS - 1; r >= 0; r--) begin
            if (w_low[r]) begin
                w_row_idx = 2'(r);
            end
        end
    end

    always_ff @(posedge int_osc or negedge reset) begin
        if (!reset) begin
            r_state   <= DRIVE;
            r_cnt     <= '0;
            r_col_idx <= 2'd0;
            r_cols    <= 4'b1110;
            r_pressed <= 1'b0;
            r_key     <= 4'h0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_col_idx <= w_col_nxt;
            r_cols    <= w_cols_nxt;
            r_pressed <= w_pressed_nxt;
            r_key     <= w_key_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_col_nxt     = r_col_idx;
        w_cols_nxt    = r_cols;
        w_pressed_nxt = r_pressed;
        w_key_nxt     = r_key;
        case (r_state)
            DRIVE: begin
                if (r_cnt == SETTLE_LAST) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = SAMPLE;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            SAMPLE: begin
                w_cnt_nxt = '0;
                if (w_single) begin
                    w_key_nxt     = KEYMAP[w_row_idx][r_col_idx];
                    w_pressed_nxt = 1'b1;
                    w_state_nxt   = HOLD;
                end else begin
                    w_col_nxt   = w_col_inc;
                    w_cols_nxt  = col_drive(w_col_inc);
                    w_state_nxt = DRIVE;
                end
            end
            HOLD: begin
                // Any low row, including a second key, restarts the release count.
                if (w_rows_s == '1) begin
                    if (r_cnt == RELEASE_LAST) begin
                        w_cnt_nxt     = '0;
                        w_pressed_nxt = 1'b0;
                        w_col_nxt     = w_col_inc;
                        w_cols_nxt    = col_drive(w_col_inc);
                        w_state_nxt   = DRIVE;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end else begin
                    w_cnt_nxt = '0;
                end
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = DRIVE;
            end
        endcase
    end

    assign cols    = r_cols;
    assign pressed = r_pressed;
    assign key     = r_key;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SETTLE_CYCLES=4, RELEASE_CYCLES=8 and a behavioural key matrix.
// Inputs change and outputs are observed on the falling edge.
module tb_keypad_scanner;

    logic       int_osc = 1'b0;
    logic       reset;
    logic [3:0] rows;
    logic [3:0] cols;
    logic       pressed;
    logic [3:0] key;

    logic [3:0] held [4];
    int checks = 0;
    int errors = 0;

    always #5 int_osc = ~int_osc;

    keypad_scanner #(
        .SETTLE_CYCLES  (4),
        .RELEASE_CYCLES (8)
    ) dut (
        .int_osc (int_osc),
        .reset   (reset),
        .rows    (rows),
        .cols    (cols),
        .pressed (pressed),
        .key     (key)
    );

    // Key at (r,c) pulls row r low only while column c is driven low.
    always_comb begin
        rows = 4'b1111;
        for (int c = 0; c < 4; c++) begin
            if (!cols[c]) begin
                for (int r = 0; r < 4; r++) begin
                    if (held[r][c]) rows[r] = 1'b0;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge int_osc);
        @(negedge int_osc);
    endtask

    initial begin
        int bad;
        logic [3:0] exp_cols;
        for (int r = 0; r < 4; r++) held[r] = 4'b0000;
        reset = 1'b0;
        repeat (2) @(negedge int_osc);
        chk("rst_cols", cols, 4'b1110);
        chk("rst_pressed", pressed, 0);
        chk("rst_key", key, 4'h0);
        reset = 1'b1;

        // Idle scan: each column held 5 cycles.
        bad = 0;
        for (int n = 1; n <= 40; n++) begin
            step(1);
            exp_cols = 4'b1111;
            exp_cols[(n / 5) % 4] = 1'b0;
            if (cols !== exp_cols || pressed !== 1'b0) bad++;
        end
        chk("idle_scan_errs", bad, 0);
        chk("idle_cols_end", cols, 4'b1110);

        // Key 8 (row2,col1): detected on col1 SAMPLE, edge 10 from here.
        held[2][1] = 1'b1;
        step(9);
        chk("press8_early", pressed, 0);
        step(1);
        chk("press8_pressed", pressed, 1);
        chk("press8_key", key, 4'h8);
        chk("press8_cols", cols, 4'b1101);
        bad = 0;
        repeat (100) begin
            step(1);
            if (cols !== 4'b1101 || pressed !== 1'b1) bad++;
        end
        chk("hold_frozen_errs", bad, 0);

        // Release, 5 high, 3-cycle bounce, final release: falls 10 edges after final release.
        held[2][1] = 1'b0;
        step(5);
        held[2][1] = 1'b1;
        step(3);
        held[2][1] = 1'b0;
        step(9);
        chk("bounce_still", pressed, 1);
        step(1);
        chk("release_pressed", pressed, 0);
        chk("release_cols", cols, 4'b1011);
        chk("release_key", key, 4'h8);

        // Multi-key in col0 is ignored; scan reaches col1.
        held[0][0] = 1'b1;
        held[3][0] = 1'b1;
        step(14);
        chk("multi_col0", cols, 4'b1110);
        step(1);
        chk("multi_pressed", pressed, 0);
        chk("multi_cols", cols, 4'b1101);
        held[0][0] = 1'b0;
        held[3][0] = 1'b0;

        // Row3 in col3 -> D.
        held[3][3] = 1'b1;
        step(14);
        chk("keyD_early", pressed, 0);
        step(1);
        chk("keyD_pressed", pressed, 1);
        chk("keyD_key", key, 4'hD);
        chk("keyD_cols", cols, 4'b0111);

        // Asynchronous reset in HOLD.
        step(3);
        reset = 1'b0;
        #1;
        chk("rst_hold_pressed", pressed, 0);
        chk("rst_hold_cols", cols, 4'b1110);
        chk("rst_hold_key", key, 4'h0);
        held[3][3] = 1'b0;
        step(2);
        reset = 1'b1;
        step(4);
        chk("resume_col0", cols, 4'b1110);
        step(1);
        chk("resume_col1", cols, 4'b1101);

        // Rollover: key 5 then extra keys 9 and 8 during HOLD.
        held[1][1] = 1'b1;
        step(4);
        chk("key5_early", pressed, 0);
        step(1);
        chk("key5_pressed", pressed, 1);
        chk("key5_key", key, 4'h5);
        held[2][2] = 1'b1;
        held[2][1] = 1'b1;
        step(20);
        chk("roll_key", key, 4'h5);
        chk("roll_pressed", pressed, 1);
        chk("roll_cols", cols, 4'b1101);
        held[1][1] = 1'b0;
        step(12);
        chk("roll_partial", pressed, 1);
        held[2][1] = 1'b0;
        held[2][2] = 1'b0;
        step(9);
        chk("roll_rel_early", pressed, 1);
        step(1);
        chk("roll_rel_pressed", pressed, 0);
        chk("roll_rel_key", key, 4'h5);
        chk("roll_rel_cols", cols, 4'b1011);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
